eq_cmp_seq: RTL

//  Multi-cycle sequencer that shares one SLICE_W-bit equality slice (XOR, then NOR-reduce)
//  to compare two DATA_W-bit operands over several cycles, LSB slice first.
//  It exits early on the first mismatching slice.
//  It sits between branch/compare issue logic and the ALU compare path of the jedro_1 core,

---
 rtl/eq_cmp_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/eq_cmp_seq.sv
// Multi-cycle equality comparator: one SLICE_W-bit XOR/NOR slice walks the operands
// LSB slice first, stopping on the first mismatching slice. Valid/ready on both sides.
module eq_cmp_seq #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               req_valid_i,
    output logic                               req_ready_o,
    input  logic [DATA_W-1:0]                  op_a_i,
    input  logic [DATA_W-1:0]                  op_b_i,
    input  logic                               op_ne_i,
    output logic                               res_valid_o,
    input  logic                               res_ready_i,
    output logic                               res_o,
    output logic [$clog2(DATA_W/SLICE_W):0]    res_nsl_o
);

    localparam int NSL   = DATA_W / SLICE_W;
    localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
    localparam int CNT_W = $clog2(NSL) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    logic [DATA_W-1:0]  op_a_reg;
    logic [DATA_W-1:0]  op_b_reg;
    logic               op_ne_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               req_ready_reg;
    logic               res_valid_reg;
    logic               res_reg;
    logic [CNT_W-1:0]   res_nsl_reg;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic               slice_eq;
    logic               last_slice;

    // Only the selected slice reaches the shared XOR/NOR-reduce.
    assign slice_a    = SLICE_W'(op_a_reg >> (idx_reg * SLICE_W));
    assign slice_b    = SLICE_W'(op_b_reg >> (idx_reg * SLICE_W));
    assign slice_eq   = ~|(slice_a ^ slice_b);
    assign last_slice = (idx_reg == IDX_W'(NSL - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            op_ne_reg     <= 1'b0;
            idx_reg       <= '0;
            req_ready_reg <= 1'b1;
            res_valid_reg <= 1'b0;
            res_reg       <= 1'b0;
            res_nsl_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid_i) begin
                        op_a_reg      <= op_a_i;
                        op_b_reg      <= op_b_i;
                        op_ne_reg     <= op_ne_i;
                        idx_reg       <= '0;
                        req_ready_reg <= 1'b0;
                        state_reg     <= RUN;
                    end
                end
                RUN: begin
                    if (!slice_eq) begin
                        res_reg       <= op_ne_reg;
                        res_nsl_reg   <= CNT_W'(idx_reg) + CNT_W'(1);
                        res_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else if (last_slice) begin
                        res_reg       <= ~op_ne_reg;
                        res_nsl_reg   <= CNT_W'(NSL);
                        res_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                DONE: begin
                    // Result fields stay put after the handshake until the next compare ends.
                    if (res_ready_i) begin
                        res_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    res_valid_reg <= 1'b0;
                    req_ready_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_reg;
    assign res_valid_o = res_valid_reg;
    assign res_o       = res_reg;
    assign res_nsl_o   = res_nsl_reg;

endmodule
